// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the dual-port BDD node SRAM: round-robin write and read grants,
// collision stall (or same-cycle bypass when SRAM_ARB_BYPASS_EN is defined), tagged read responses.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 34,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [ADDR_WIDTH-1:0]   addr_a,
   output logic [DATA_WIDTH-1:0]   data_a,
   output logic                    we_a,
   output logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic [DATA_WIDTH-1:0]   q_b,
   output logic [CNT_WIDTH-1:0]    collision_cnt
);

   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_rsp_valid;
   logic [CNT_WIDTH-1:0]  r_coll_cnt;
`ifdef SRAM_ARB_BYPASS_EN
   logic                  r_byp_hit;
   logic [DATA_WIDTH-1:0] r_byp_data;
`endif

   logic [1:0]            w_wr_cand;
   logic [1:0]            w_rd_cand;
   logic                  w_wr_any;
   logic                  w_rd_any;
   logic                  w_wr_sel;
   logic                  w_rd_sel;
   logic                  w_wr_gnt;
   logic                  w_rd_gnt;
   logic                  w_collision;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;

   always_comb begin
      w_wr_cand = req_valid & req_we;
      w_rd_cand = req_valid & ~req_we;
      w_wr_any  = |w_wr_cand;
      w_rd_any  = |w_rd_cand;
      // Pointer only matters when both requesters compete.
      w_wr_sel  = (&w_wr_cand) ? r_wr_ptr : w_wr_cand[1];
      w_rd_sel  = (&w_rd_cand) ? r_rd_ptr : w_rd_cand[1];
      w_wr_addr = w_wr_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      w_rd_addr = w_rd_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      w_wr_data = w_wr_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      w_wr_gnt  = w_wr_any & ~rst;
      w_collision = w_wr_gnt & w_rd_any & (w_wr_addr == w_rd_addr);
`ifdef SRAM_ARB_BYPASS_EN
      w_rd_gnt  = w_rd_any & ~rst;
`else
      w_rd_gnt  = w_rd_any & ~rst & ~w_collision;
`endif
   end

   always_comb begin
      req_ready = '0;
      we_a      = 1'b0;
      addr_a    = '0;
      data_a    = '0;
      addr_b    = '0;
      if (w_wr_gnt) begin
         req_ready[w_wr_sel] = 1'b1;
         we_a   = 1'b1;
         addr_a = w_wr_addr;
         data_a = w_wr_data;
      end
      if (w_rd_gnt) begin
         req_ready[w_rd_sel] = 1'b1;
         addr_b = w_rd_addr;
      end
   end

   // Gating by rst drops a response whose read was granted just before reset.
   always_comb begin
      rsp_valid = r_rsp_valid & {2{~rst}};
      rsp_rdata = '0;
      if (|rsp_valid) begin
`ifdef SRAM_ARB_BYPASS_EN
         rsp_rdata = r_byp_hit ? r_byp_data : q_b;
`else
         rsp_rdata = q_b;
`endif
      end
   end

   assign collision_cnt = r_coll_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_rsp_valid <= '0;
         r_coll_cnt  <= '0;
      end else begin
         if (w_wr_gnt) r_wr_ptr <= ~w_wr_sel;
         if (w_rd_gnt) r_rd_ptr <= ~w_rd_sel;
         r_rsp_valid <= {w_rd_gnt & w_rd_sel, w_rd_gnt & ~w_rd_sel};
         if (w_collision && (r_coll_cnt != '1))
            r_coll_cnt <= r_coll_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

`ifdef SRAM_ARB_BYPASS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byp_hit  <= 1'b0;
         r_byp_data <= '0;
      end else begin
         r_byp_hit  <= w_collision;
         if (w_collision) r_byp_data <= w_wr_data;
      end
   end
`endif

endmodule
